// File: rtl/extbus_pkg.sv
// Shared types and constants for the 65C02-style external bus responder.
package extbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } extbus_state_e;

    localparam int EXTBUS_ADDR_W = 5;

    localparam logic [EXTBUS_ADDR_W-1:0] REG_ADDRX_L = 5'h00;
    localparam logic [EXTBUS_ADDR_W-1:0] REG_ADDRX_M = 5'h01;
    localparam logic [EXTBUS_ADDR_W-1:0] REG_ADDRX_H = 5'h02;
    localparam logic [EXTBUS_ADDR_W-1:0] REG_DATA0   = 5'h03;
    localparam logic [EXTBUS_ADDR_W-1:0] REG_DATA1   = 5'h04;
    localparam logic [EXTBUS_ADDR_W-1:0] REG_CTRL    = 5'h05;

    // A strobe only counts while the chip is selected.
    function automatic logic strobe_active(input logic cs_n, input logic strobe_n);
        return ~cs_n & ~strobe_n;
    endfunction

endpackage

// File: rtl/extbus_sync.sv
// N-stage flop synchronizer for one asynchronous strobe; exposes the first
// stage (for data capture) and the last stage (for control decisions).
module extbus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q_first,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q_first = chain_r[0];
    assign q       = chain_r[STAGES-1];

endmodule

// File: rtl/extbus_responder.sv
// External bus responder: synchronizes cs_n/rd_n/wr_n into clk25 and issues
// register write / read-complete pulses. Optional macro: EXTBUS_RD_DONE_EN.
module extbus_responder
    import extbus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = EXTBUS_ADDR_W
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic              extbus_cs_n,
    input  logic              extbus_rd_n,
    input  logic              extbus_wr_n,
    input  logic [ADDR_W-1:0] extbus_a,
    input  logic [7:0]        extbus_d_in,
    output logic [7:0]        extbus_d_out,
    output logic              extbus_d_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wr_data,
    output logic              reg_wr_strobe,
    input  logic [7:0]        reg_rd_data,
    output logic              reg_rd_done,
    output logic              bus_busy
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SYNC_STAGES);

    logic          wr_raw_s;
    logic          rd_raw_s;
    logic          wr_s1_s;
    logic          rd_s1_s;
    logic          wr_s;
    logic          rd_s;
    logic          settled_s;
    logic [CNT_W-1:0] settle_cnt_r;
    logic          wr_arm_r;
    logic          rd_arm_r;
    extbus_state_e state_r;

    assign wr_raw_s = strobe_active(extbus_cs_n, extbus_wr_n);
    assign rd_raw_s = strobe_active(extbus_cs_n, extbus_rd_n);

    // Pad driver enable comes straight from the pins so turnaround is not delayed.
    assign extbus_d_oe = rd_raw_s;

    extbus_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .clk     (clk25),
        .reset   (reset),
        .d       (wr_raw_s),
        .q_first (wr_s1_s),
        .q       (wr_s)
    );

    extbus_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .clk     (clk25),
        .reset   (reset),
        .d       (rd_raw_s),
        .q_first (rd_s1_s),
        .q       (rd_s)
    );

    // The chains hold reset zeros for SYNC_STAGES cycles; only then is wr_s/rd_s trustworthy.
    assign settled_s = (settle_cnt_r == SETTLE_MAX);

    // Address/data capture while the first sync stage reports an active strobe.
    always_ff @(posedge clk25) begin
        if (reset) begin
            reg_addr    <= {ADDR_W{1'b0}};
            reg_wr_data <= 8'h00;
        end else if (wr_s1_s) begin
            reg_addr    <= extbus_a;
            reg_wr_data <= extbus_d_in;
        end else if (rd_s1_s) begin
            reg_addr    <= extbus_a;
            reg_wr_data <= reg_wr_data;
        end else begin
            reg_addr    <= reg_addr;
            reg_wr_data <= reg_wr_data;
        end
    end

    // Access FSM with registered pulses, busy flag and read-data latch.
    always_ff @(posedge clk25) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            settle_cnt_r  <= {CNT_W{1'b0}};
            wr_arm_r      <= 1'b0;
            rd_arm_r      <= 1'b0;
            reg_wr_strobe <= 1'b0;
            bus_busy      <= 1'b0;
            extbus_d_out  <= 8'h00;
        end else begin
            reg_wr_strobe <= 1'b0;
            if (!settled_s) begin
                settle_cnt_r <= settle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
            // A strobe must be seen idle before it may start an access.
            if (settled_s && !wr_s) begin
                wr_arm_r <= 1'b1;
            end
            if (settled_s && !rd_s) begin
                rd_arm_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (wr_s && wr_arm_r) begin
                        state_r  <= ST_WRITE;
                        bus_busy <= 1'b1;
                        if (rd_s) begin
                            rd_arm_r <= 1'b0;
                        end
                    end else if (rd_s && rd_arm_r) begin
                        state_r      <= ST_READ;
                        bus_busy     <= 1'b1;
                        extbus_d_out <= reg_rd_data;
                    end else begin
                        bus_busy <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (!wr_s) begin
                        reg_wr_strobe <= 1'b1;
                        state_r       <= ST_IDLE;
                        bus_busy      <= 1'b0;
                    end
                end
                ST_READ: begin
                    extbus_d_out <= reg_rd_data;
                    if (!rd_s) begin
                        state_r  <= ST_IDLE;
                        bus_busy <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXTBUS_RD_DONE_EN
    // Read-complete pulse on the synchronized rd fall while reading.
    always_ff @(posedge clk25) begin
        if (reset) begin
            reg_rd_done <= 1'b0;
        end else begin
            reg_rd_done <= (state_r == ST_READ) && !rd_s;
        end
    end
`else
    assign reg_rd_done = 1'b0;
`endif

endmodule

// File: doc/extbus_responder.md
# extbus_responder

Synthesizable responder for the 65C02-style external bus (8 MHz phi2-qualified strokes, active-low `cs_n`, `rd_n`, `wr_n`) in the `clk25` domain.
- Synchronizes the asynchronous strobes and captures address and write data.
- Emits single-cycle register write and read-complete pulses to the register file.
- Drives read data onto the shared data bus.
- Sits between the top-level `extbus_*` pins and the VERA register/VRAM-port logic.

## Interface
- `SYNC_STAGES`, 2, flip-flops per strobe synchronizer (≥2).
- `ADDR_W`, 5, register address width.
- `clk25` in 1: system clock, 25 MHz.
- `reset` in 1: synchronous, active-high.
- `extbus_cs_n` in 1: chip select, asynchronous.
- `extbus_rd_n` in 1: read strobe, asynchronous.
- `extbus_wr_n` in 1: write strobe, asynchronous.
- `extbus_a` in ADDR_W: register address, asynchronous.
- `extbus_d_in` in 8: data from the pad.
- `extbus_d_out` out 8: data to the pad.
- `extbus_d_oe` out 1: pad output enable.
- `reg_addr` out ADDR_W: address for write, or read address (held during read).
- `reg_wr_data` out 8: captured write data.
- `reg_wr_strobe` out 1: one-cycle write commit.
- `reg_rd_data` in 8: register file read data for `reg_addr`.
- `reg_rd_done` out 1: one-cycle pulse at end of read, for auto-increment side effects.
- `bus_busy` out 1: FSM not in IDLE.

## Operation
- Strobes are qualified as `wr = !cs_n & !wr_n` and `rd = !cs_n & !rd_n`. Each passes through a SYNC_STAGES flop chain; `wr_s` and `rd_s` are the final stages.
- Capture: on every `clk25` edge where stage-1 `wr` is high, `extbus_a` → `reg_addr` and `extbus_d_in` → `reg_wr_data`. The last capture before the strobe ends wins.
- FSM states:
  - **IDLE**: `wr_s` → WRITE; `rd_s` (and not `wr_s`) → READ. If both assert, WRITE wins and the read is ignored until `rd_s` reasserts after IDLE.
  - **WRITE**: hold until `wr_s` falls. On the fall, pulse `reg_wr_strobe` for one cycle and go to IDLE.
  - **READ**: on entry, latch `reg_rd_data` → `extbus_d_out`. Refresh the latch each cycle while in READ. On the `rd_s` fall, pulse `reg_rd_done` and go to IDLE.
- `reg_addr` follows `extbus_a` while stage-1 `rd` is high and is held otherwise.
- `extbus_d_oe = !cs_n & !rd_n`, combinational from the pins, so bus turnaround is not delayed by sync latency. `extbus_d_out` is the registered latch.
- Strobe fall while `cs_n` is deasserted still completes the access.
- Reset mid-access: the FSM goes to IDLE with no pulse emitted. The in-flight strobe is ignored until it deasserts and reasserts.

## Timing
- Reset values:
  - `extbus_d_out`=0x00, `reg_addr`=0, `reg_wr_data`=0x00.
  - `reg_wr_strobe`=0, `reg_rd_done`=0, `bus_busy`=0, state IDLE, sync chains all 0 (idle).
  - `extbus_d_oe` is combinational and not reset.
- Minimum strobe low width 62.5 ns (at least one `clk25` sample is guaranteed). Minimum strobe high between accesses 2 `clk25` cycles.
- `reg_wr_strobe` fires SYNC_STAGES+1 cycles after the `wr_n` rise. `reg_rd_done` has the same latency after the `rd_n` rise.
- Read data: `reg_rd_data` is combinational from `reg_addr` in the register file. `extbus_d_out` is valid SYNC_STAGES+1 cycles after `rd_n` falls (≤120 ns).
- Throughput: one access per phi2 cycle (125 ns), pulses spaced ≥3 clocks apart.

## Configuration
- `EXTBUS_RD_DONE_EN`
  - Defined: `reg_rd_done` pulses as specified.
  - Undefined: `reg_rd_done` is tied 0 and READ returns to IDLE without side-effect logic, for register files with no read auto-increment.

## Structure
- Shared package `extbus_pkg`:
  - FSM state enum (IDLE, WRITE, READ).
  - `EXTBUS_ADDR_W`=5.
  - Register offset constants (ADDRx_L=0x00, ADDRx_M=0x01, ADDRx_H=0x02, DATA0=0x03, DATA1=0x04, CTRL=0x05).
- One sub-module: `extbus_sync`, a parameterized N-stage synchronizer instanced twice (wr, rd).

## Test plan
- Write 0x01 to offset 0x05 (phi2 8 MHz, data valid 25 ns after phi2 rise, held 10 ns past fall) → exactly one `reg_wr_strobe`, with `reg_addr`=0x05 and `reg_wr_data`=0x01, within 3 clocks of the `wr_n` rise.
- Back-to-back writes 0x00/0x40/0x10 to offsets 0x00/0x01/0x02, then 0xA1..0xA4 to 0x04 → seven strobes in order with matching addr/data, none dropped or duplicated.
- Read offset 0x04 with `reg_rd_data`=0xA1 → `extbus_d_oe` high only during `rd_n` low; `extbus_d_out`=0xA1 before the `rd_n` rise; one `reg_rd_done`. Repeat four times with 0xA1..0xA4 returned → four pulses, correct bytes.
- `cs_n` high (address 0x0000) with strobes toggling → no pulses, `extbus_d_oe`=0, `bus_busy`=0.
- `reset` asserted midway through a write strobe → no `reg_wr_strobe`, all outputs at reset values. The next full write commits normally.
- Build without `EXTBUS_RD_DONE_EN` → reads still return data, `reg_rd_done` stays 0.
